// File: rtl/stream_demux.sv
// Routes one upstream word per cycle to one of N_OUT single-slot output channels; STREAM_DEMUX_COUNT_EN adds per-channel transfer counters.
// Latency: 1 cycle from upstream accept to down_valid. Backpressure: up_ready follows the selected slot only,
// so a stalled channel never blocks traffic to other channels; out-of-range selects are always accepted and dropped.
module stream_demux #(
    parameter int N_OUT = 4,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       up_valid,
    output logic                       up_ready,
    input  logic [W-1:0]               up_data,
    input  logic [$clog2(N_OUT)-1:0]   up_sel,
    output logic [N_OUT-1:0]           down_valid,
    input  logic [N_OUT-1:0]           down_ready,
    output logic [N_OUT*W-1:0]         down_data,
    output logic                       err_drop
`ifdef STREAM_DEMUX_COUNT_EN
    ,
    output logic [N_OUT*16-1:0]        count
`endif
);

    localparam int SW = $clog2(N_OUT);

    logic [N_OUT-1:0]   full;
    logic [N_OUT-1:0]   hit;
    logic [N_OUT-1:0]   acc;
    logic [N_OUT-1:0]   drain;
    logic [N_OUT*W-1:0] data_q;
    logic               in_range;

    // up_ready is derived from slot state and down_ready only, never from up_valid.
    always_comb begin
        hit      = '0;
        in_range = (32'(up_sel) < 32'(N_OUT));
        for (int i = 0; i < N_OUT; i++) begin
            hit[i] = (up_sel == SW'(i));
        end
        up_ready = ~in_range | (|(hit & (~full | down_ready)));
        acc      = hit & {N_OUT{up_valid & up_ready & in_range}};
        drain    = full & down_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full     <= '0;
            err_drop <= 1'b0;
        end else begin
            full     <= acc | (full & ~drain);
            err_drop <= up_valid & ~in_range;
        end
    end

    // Payload needs no reset: it is only observed while its slot is full.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_OUT; i++) begin
            if (acc[i]) begin
                data_q[i*W +: W] <= up_data;
            end
        end
    end

    assign down_valid = full;
    assign down_data  = data_q;

`ifdef STREAM_DEMUX_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                if (drain[i] && (count[i*16 +: 16] != 16'hFFFF)) begin
                    count[i*16 +: 16] <= count[i*16 +: 16] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: a 4-channel and a 3-channel instance checked against a slot-level reference model.
module tb_stream_demux;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 4-channel instance
    logic        v0 = 1'b0;
    logic [1:0]  s0 = '0;
    logic [7:0]  d0 = '0;
    logic [3:0]  r0 = '0;
    logic        ur4, ed4;
    logic [3:0]  dv4;
    logic [31:0] dd4;
    // 3-channel instance (select value 3 is out of range)
    logic        v1 = 1'b0;
    logic [1:0]  s1 = '0;
    logic [7:0]  d1 = '0;
    logic [2:0]  r1 = '0;
    logic        ur3, ed3;
    logic [2:0]  dv3;
    logic [23:0] dd3;
`ifdef STREAM_DEMUX_COUNT_EN
    logic [63:0] cnt4;
    logic [47:0] cnt3;
`endif

    stream_demux #(.N_OUT(4), .W(8)) dut4 (
        .clk(clk), .rst(rst), .up_valid(v0), .up_ready(ur4), .up_data(d0), .up_sel(s0),
        .down_valid(dv4), .down_ready(r0), .down_data(dd4), .err_drop(ed4)
`ifdef STREAM_DEMUX_COUNT_EN
        , .count(cnt4)
`endif
    );

    stream_demux #(.N_OUT(3), .W(8)) dut3 (
        .clk(clk), .rst(rst), .up_valid(v1), .up_ready(ur3), .up_data(d1), .up_sel(s1),
        .down_valid(dv3), .down_ready(r1), .down_data(dd3), .err_drop(ed3)
`ifdef STREAM_DEMUX_COUNT_EN
        , .count(cnt3)
`endif
    );

    // Reference model: per instance, per channel slot occupancy, held word, transfer count.
    bit         mf [2][4];
    logic [7:0] md [2][4];
    bit         me [2];
    int         mc [2][4];

    int nchk  = 0;
    int nfail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        nchk++;
        assert (obs === exp_v) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [7:0] out_data(input int k, input int ch);
        return (k == 0) ? dd4[ch*8 +: 8] : dd3[ch*8 +: 8];
    endfunction

`ifdef STREAM_DEMUX_COUNT_EN
    function automatic logic [15:0] out_cnt(input int k, input int ch);
        return (k == 0) ? cnt4[ch*16 +: 16] : cnt3[ch*16 +: 16];
    endfunction
`endif

    // Caller sets inputs just after a falling edge; this checks everything, advances the model,
    // and returns at the next falling edge.
    task automatic cyc();
        #1;
        for (int k = 0; k < 2; k++) begin
            int         n   = (k == 0) ? 4 : 3;
            int         sel = (k == 0) ? int'(s0) : int'(s1);
            logic       v   = (k == 0) ? v0 : v1;
            logic [7:0] dat = (k == 0) ? d0 : d1;
            logic [3:0] rdy = (k == 0) ? r0 : {1'b0, r1};
            logic [3:0] dv  = (k == 0) ? dv4 : {1'b0, dv3};
            logic       ur  = (k == 0) ? ur4 : ur3;
            logic       ed  = (k == 0) ? ed4 : ed3;
            bit         exp_ur;
            exp_ur = (sel >= n) ? 1'b1 : (!mf[k][sel] || rdy[sel]);
            check($sformatf("up_ready[%0d]", k), {63'd0, ur}, {63'd0, exp_ur});
            check($sformatf("err_drop[%0d]", k), {63'd0, ed}, {63'd0, me[k]});
            for (int ch = 0; ch < n; ch++) begin
                check($sformatf("down_valid[%0d][%0d]", k, ch), {63'd0, dv[ch]}, {63'd0, mf[k][ch]});
                if (mf[k][ch])
                    check($sformatf("down_data[%0d][%0d]", k, ch), {56'd0, out_data(k, ch)}, {56'd0, md[k][ch]});
`ifdef STREAM_DEMUX_COUNT_EN
                check($sformatf("count[%0d][%0d]", k, ch), {48'd0, out_cnt(k, ch)}, 64'(mc[k][ch]));
`endif
            end
            if (rst) begin
                for (int ch = 0; ch < 4; ch++) begin
                    mf[k][ch] = 0;
                    mc[k][ch] = 0;
                end
                me[k] = 0;
            end else begin
                for (int ch = 0; ch < n; ch++) begin
                    bit drn = mf[k][ch] && rdy[ch];
                    bit take = v && exp_ur && (sel == ch);
                    if (drn && mc[k][ch] < 65535) mc[k][ch]++;
                    mf[k][ch] = take || (mf[k][ch] && !drn);
                    if (take) md[k][ch] = dat;
                end
                me[k] = v && (sel >= n);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [7:0] sent [$];
    int         seen;

    initial begin
        for (int k = 0; k < 2; k++) begin
            me[k] = 0;
            for (int ch = 0; ch < 4; ch++) begin
                mf[k][ch] = 0; md[k][ch] = '0; mc[k][ch] = 0;
            end
        end
        @(negedge clk);

        // Reset state
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        check("reset dv4", 64'(dv4), 64'h0);
        check("reset dv3", 64'(dv3), 64'h0);
        check("reset err_drop", {62'd0, ed4, ed3}, 64'h0);

        // Single word into a stalled channel 2
        v0 = 1'b1; s0 = 2'd2; d0 = 8'hA5; r0 = 4'b0000;
        cyc();
        check("ch2 valid", 64'(dv4), 64'h4);
        check("ch2 data", 64'(dd4[23:16]), 64'hA5);
        d0 = 8'h77;
        #1;
        check("ch2 full not ready", 64'(ur4), 64'h0);
        cyc();

        // Drain and refill channel 2 in the same cycle
        r0 = 4'b0100; d0 = 8'h3C;
        #1;
        check("drain+accept ready", 64'(ur4), 64'h1);
        cyc();
        check("refill data", 64'(dd4[23:16]), 64'h3C);
        check("refill valid", 64'(dv4[2]), 64'h1);

        // Stalled channel 0 must not block channel 1
        r0 = 4'b0000; s0 = 2'd0; d0 = 8'h55;
        cyc();
        s0 = 2'd1; d0 = 8'h11;
        #1;
        check("other ch ready", 64'(ur4), 64'h1);
        cyc();
        check("ch1 valid", 64'(dv4[1]), 64'h1);
        check("ch1 data", 64'(dd4[15:8]), 64'h11);
        check("ch0 held", 64'(dd4[7:0]), 64'h55);
        v0 = 1'b0;

        // Out-of-range select on the 3-channel instance
        v1 = 1'b1; s1 = 2'd3; d1 = 8'hEE; r1 = 3'b000;
        #1;
        check("oor ready", 64'(ur3), 64'h1);
        cyc();
        check("oor err_drop", 64'(ed3), 64'h1);
        check("oor no delivery", 64'(dv3), 64'h0);
        v1 = 1'b0;
        cyc();
        check("err_drop one pulse", 64'(ed3), 64'h0);

        // 100 back-to-back words to channel 3 with its consumer always ready
        r0 = 4'b1000; v0 = 1'b1; s0 = 2'd3;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            d0 = 8'($urandom);
            sent.push_back(d0);
            cyc();
            if (dv4[3]) begin
                check($sformatf("stream order %0d", seen), 64'(dd4[31:24]), 64'(sent[seen]));
                seen++;
            end
        end
        v0 = 1'b0;
        cyc();
        check("stream transfers", 64'(seen), 64'd100);
        check("stream drained", 64'(dv4[3]), 64'h0);
`ifdef STREAM_DEMUX_COUNT_EN
        check("stream count", 64'(cnt4[63:48]), 64'd100);
`endif

        // Randomised traffic on both instances, occasional reset
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            v0 = 1'($urandom); s0 = 2'($urandom); d0 = 8'($urandom); r0 = 4'($urandom);
            v1 = 1'($urandom); s1 = 2'($urandom); d1 = 8'($urandom); r1 = 3'($urandom);
            cyc();
        end
        rst = 1'b0;

        // Fill every slot, then reset
        r0 = '0; r1 = '0; v0 = 1'b1; v1 = 1'b1;
        for (int c = 0; c < 4; c++) begin
            s0 = 2'(c); s1 = 2'(c); d0 = 8'($urandom); d1 = 8'($urandom);
            cyc();
        end
        v0 = 1'b0; v1 = 1'b0;
        check("all full dv4", 64'(dv4), 64'hF);
        check("all full dv3", 64'(dv3), 64'h7);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("post-reset dv4", 64'(dv4), 64'h0);
        check("post-reset dv3", 64'(dv3), 64'h0);
        check("post-reset err_drop", {62'd0, ed4, ed3}, 64'h0);
`ifdef STREAM_DEMUX_COUNT_EN
        check("post-reset cnt4", cnt4, 64'h0);
        check("post-reset cnt3", 64'(cnt3), 64'h0);
`endif
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end

endmodule
